// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds widths, the NOP word and the next-PC select encoding.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_JMP = 2'd2,
        PC_SRC_RSV = 2'd3
    } pc_src_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold and flush-to-bubble.
// Async active-high reset loads a NOP bubble.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_pc_plus1,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_pc_plus1,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc_plus1;
    logic              r_valid;

    // Capture fetched word, insert bubble on flush, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (i_stall) begin
            r_instr    <= r_instr;
            r_pc_plus1 <= r_pc_plus1;
            r_valid    <= r_valid;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= 1'b0;
        end else begin
            r_instr    <= i_instr;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register.
// Optional macro IF_PERF_CNT_EN adds fetch/stall/flush counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'd0,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD,
    parameter logic [WORD_W-1:0] PC_STEP   = 32'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic [1:0]        i_pc_src,
    input  logic [WORD_W-1:0] i_branch_target,
    input  logic [JIDX_W-1:0] i_jump_index,
    input  logic              i_flush,
    output logic [WORD_W-1:0] o_imem_addr,
    input  logic [WORD_W-1:0] i_imem_instr,
    output logic [WORD_W-1:0] o_ifid_instr,
    output logic [WORD_W-1:0] o_ifid_pc_plus1,
`ifdef IF_PERF_CNT_EN
    output logic [WORD_W-1:0] o_fetch_cnt,
    output logic [WORD_W-1:0] o_stall_cnt,
    output logic [WORD_W-1:0] o_flush_cnt,
`endif
    output logic              o_ifid_valid
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_plus1;
    logic [WORD_W-1:0] w_jump_target;
    logic [WORD_W-1:0] w_next_pc;

    assign w_pc_plus1    = r_pc + PC_STEP;
    assign w_jump_target = {o_ifid_pc_plus1[WORD_W-1:JIDX_W], i_jump_index};
    assign o_imem_addr   = r_pc;

    // Next-PC select; the reserved encoding falls back to sequential.
    always_comb begin
        w_next_pc = w_pc_plus1;
        case (pc_src_e'(i_pc_src))
            PC_SRC_BR:  w_next_pc = i_branch_target;
            PC_SRC_JMP: w_next_pc = w_jump_target;
            default:    w_next_pc = w_pc_plus1;
        endcase
    end

    // PC register advances on every unstalled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (!i_stall) begin
            r_pc <= w_next_pc;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (i_stall),
        .i_flush   (i_flush),
        .i_instr   (i_imem_instr),
        .i_pc_plus1(w_pc_plus1),
        .o_instr   (o_ifid_instr),
        .o_pc_plus1(o_ifid_pc_plus1),
        .o_valid   (o_ifid_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [WORD_W-1:0] r_fetch_cnt;
    logic [WORD_W-1:0] r_stall_cnt;
    logic [WORD_W-1:0] r_flush_cnt;

    // Event counters; each wraps modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else if (i_flush) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// Memory model: word at address k is 32'h1000_0000 + k.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] s_stall;
    logic [31:0] s_flush;
`endif

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .i_stall        (stall),
        .i_pc_src       (pc_src),
        .i_branch_target(branch_target),
        .i_jump_index   (jump_index),
        .i_flush        (flush),
        .o_imem_addr    (imem_addr),
        .i_imem_instr   (imem_instr),
        .o_ifid_instr   (ifid_instr),
        .o_ifid_pc_plus1(ifid_pc_plus1),
`ifdef IF_PERF_CNT_EN
        .o_fetch_cnt    (fetch_cnt),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt),
`endif
        .o_ifid_valid   (ifid_valid)
    );

    assign imem_instr = 32'h1000_0000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        pc_src = 2'd0;
        branch_target = 32'd0;
        jump_index = 26'd0;
        flush = 1'b0;
        @(negedge clk);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_pp1", ifid_pc_plus1, 32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_fcnt", fetch_cnt, 32'd0);
`endif

        // Free run for 3 edges
        rst = 1'b0;
        step(3);
        chk("run_instr", ifid_instr, 32'h1000_0002);
        chk("run_pp1", ifid_pc_plus1, 32'd3);
        chk("run_valid", {31'd0, ifid_valid}, 32'd1);
        chk("run_addr", imem_addr, 32'd3);

        // Stall two edges at pc=5
        step(2);
        chk("pre_stall_addr", imem_addr, 32'd5);
        stall = 1'b1;
        step(2);
        chk("stall_addr", imem_addr, 32'd5);
        chk("stall_instr", ifid_instr, 32'h1000_0004);
        chk("stall_pp1", ifid_pc_plus1, 32'd5);
        stall = 1'b0;
        step(1);
        chk("unstall_instr", ifid_instr, 32'h1000_0005);
        chk("unstall_addr", imem_addr, 32'd6);

        // Branch with flush at pc=9
        step(3);
        chk("pre_br_addr", imem_addr, 32'd9);
        pc_src = 2'd1;
        branch_target = 32'd20;
        flush = 1'b1;
        step(1);
        chk("br_addr", imem_addr, 32'd20);
        chk("br_instr", ifid_instr, 32'd0);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        chk("br_pp1", ifid_pc_plus1, 32'd10);
        pc_src = 2'd0;
        flush = 1'b0;
        step(1);
        chk("br_tgt_instr", ifid_instr, 32'h1000_0014);
        chk("br_tgt_valid", {31'd0, ifid_valid}, 32'd1);

        // Branch without flush: wrong-path word enters IF/ID
        pc_src = 2'd1;
        branch_target = 32'd11;
        step(1);
        chk("nf_addr", imem_addr, 32'd11);
        chk("nf_instr", ifid_instr, 32'h1000_0015);
        chk("nf_valid", {31'd0, ifid_valid}, 32'd1);
        pc_src = 2'd3;
        step(1);
        chk("rsv_addr", imem_addr, 32'd12);
        chk("j_pre_pp1", ifid_pc_plus1, 32'd12);

        // Jump with flush
        pc_src = 2'd2;
        jump_index = 26'd4;
        flush = 1'b1;
        step(1);
        chk("jmp_addr", imem_addr, 32'd4);
        chk("jmp_valid", {31'd0, ifid_valid}, 32'd0);
        pc_src = 2'd0;
        flush = 1'b0;

        // PC wrap at all-ones
        pc_src = 2'd1;
        branch_target = 32'hFFFF_FFFF;
        step(1);
        chk("max_addr", imem_addr, 32'hFFFF_FFFF);
        pc_src = 2'd0;
        step(1);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_pp1", ifid_pc_plus1, 32'd0);
        chk("wrap_instr", ifid_instr, 32'h0FFF_FFFF);

        // Jump keeps upper 6 bits of ifid_pc_plus1
        pc_src = 2'd1;
        branch_target = 32'hFC00_0010;
        step(1);
        pc_src = 2'd0;
        step(1);
        chk("hi_pp1", ifid_pc_plus1, 32'hFC00_0011);
        pc_src = 2'd2;
        jump_index = 26'd4;
        flush = 1'b1;
        step(1);
        chk("hi_jmp_addr", imem_addr, 32'hFC00_0004);

        // Stall with flush and branch: nothing changes
`ifdef IF_PERF_CNT_EN
        s_stall = stall_cnt;
        s_flush = flush_cnt;
`endif
        stall = 1'b1;
        pc_src = 2'd1;
        branch_target = 32'd20;
        step(1);
        chk("sf_addr", imem_addr, 32'hFC00_0004);
        chk("sf_pp1", ifid_pc_plus1, 32'hFC00_0012);
        chk("sf_valid", {31'd0, ifid_valid}, 32'd0);
        chk("sf_instr", ifid_instr, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("sf_scnt", stall_cnt, s_stall + 32'd1);
        chk("sf_fcnt", flush_cnt, s_flush);
`endif
        stall = 1'b0;
        flush = 1'b0;
        pc_src = 2'd0;

        // Async reset mid-cycle at pc=7
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(7);
        chk("pre_arst_addr", imem_addr, 32'd7);
        chk("pre_arst_valid", {31'd0, ifid_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_instr", ifid_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("resume_addr", imem_addr, 32'd1);
        chk("resume_instr", ifid_instr, 32'h1000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the PC register and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Accepts stall from the hazard unit, plus flush/redirect (branch, jump) resolved in ID.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset (word address).
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset.
- PC_STEP, 32'd1, sequential PC increment; memory is word-addressed, so 1 = next instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit hold: PC and IF/ID keep their values.
- pc_src  input  2  next-PC select: 0 sequential, 1 branch, 2 jump, 3 reserved (treated as 0).
- branch_target  input  32  branch destination word address from ID.
- jump_index  input  26  instruction-index field of the jump in ID.
- flush  input  1  squash the instruction currently being fetched.
- imem_addr  output  32  address to instruction memory (= pc, combinational).
- imem_instr  input  32  instruction returned by memory in the same cycle.
- ifid_instr  output  32  registered instruction for ID.
- ifid_pc_plus1  output  32  registered pc+PC_STEP for ID.
- ifid_valid  output  1  1 = ifid_instr is a real fetched instruction.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus1=0, ifid_valid=0. Deasserting rst mid-operation resumes fetch from RESET_PC on the next edge.
- imem_addr = pc, purely combinational; memory latency is zero, so the instruction is sampled on the same edge that advances pc.
- pc_plus1 = pc + PC_STEP, 32-bit modulo; wraps 32'hFFFF_FFFF -> 0 without error.
- Jump target = {ifid_pc_plus1[31:26], jump_index}.
- next_pc by pc_src: 0 -> pc_plus1; 1 -> branch_target; 2 -> jump target; 3 -> pc_plus1.
- Per-edge priority:
  1. rst.
  2. stall=1: pc, ifid_instr, ifid_pc_plus1 and ifid_valid all hold. flush and pc_src are ignored, because ID re-presents them once the stall ends.
  3. flush=1: pc<=next_pc, ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc_plus1<=pc_plus1.
  4. Normal: pc<=next_pc, ifid_instr<=imem_instr, ifid_pc_plus1<=pc_plus1, ifid_valid<=1.
- Redirect without flush is legal: the wrong-path instruction enters IF/ID. Used for delay-slot style, and is the controller's choice.
- Latency: the instruction at address A is visible on ifid_instr one edge after pc==A. A taken redirect costs exactly one bubble when asserted together with flush.
- No FSM beyond the pc / IF/ID registers. Throughput is one instruction per unstalled cycle.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt, stall_cnt, flush_cnt (32 bits each), all reset to 0.
  - fetch_cnt increments on each normal-path capture (ifid_valid<=1).
  - stall_cnt increments on each edge with stall=1 outside reset.
  - flush_cnt increments on each edge with flush=1 and stall=0.
  - All three wrap modulo 2^32.
- Undefined: counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SRC_SEQ=2'd0, PC_SRC_BR=2'd1, PC_SRC_JMP=2'd2;
  - NOP word constant;
  - WORD_W=32, JIDX_W=26.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with stall/flush/valid.
- PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset then free-run, memory word k = 32'h1000_0000+k:
  - after 3 edges, ifid_instr=32'h1000_0002, ifid_pc_plus1=3, ifid_valid=1, imem_addr=3.
- Assert rst asynchronously mid-cycle at pc=7:
  - immediately pc=0, ifid_valid=0, ifid_instr=0 without waiting for a clock edge.
- stall=1 for 2 edges at pc=5:
  - imem_addr stays 5 and ifid_instr/ifid_pc_plus1 unchanged;
  - after release, next edge captures word 5 and pc=6.
- pc_src=1, branch_target=32'd20, flush=1 at pc=9:
  - next edge pc=20, ifid_instr=NOP, ifid_valid=0;
  - following edge ifid_instr=word 20.
- pc_src=2, jump_index=26'd4, flush=1, ifid_pc_plus1=12:
  - next edge pc=4, ifid_valid=0.
- stall=1 together with flush=1, pc_src=1:
  - no state change on that edge;
  - with IF_PERF_CNT_EN, stall_cnt+1 and flush_cnt unchanged.
